// File: rtl/d2b_pkg.sv
// Shared types and constants for the decimal-to-binary entry controller.
package d2b_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] MAX_DEC_DIGIT = 4'd9;

  typedef enum logic [2:0] {
    ST_COLLECT = 3'd0,
    ST_MUL     = 3'd1,
    ST_ADD     = 3'd2,
    ST_HOLD    = 3'd3,
    ST_ERR     = 3'd4
  } state_e;

endpackage

// File: rtl/d2b_mul10.sv
// Combinational multiply-by-ten as two shifts and an add; output widened by 4 bits
// so any overflow beyond WIDTH is visible in the top nibble.
module d2b_mul10 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] x_i,
  output logic [WIDTH+3:0] prod_o
);

  logic [WIDTH+3:0] x_ext;

  assign x_ext  = (WIDTH+4)'(x_i);
  assign prod_o = (x_ext << 3) + (x_ext << 1);

endmodule

// File: rtl/d2b_entry_ctrl.sv
// Decimal digit entry sequencer: acc = acc*10 + digit over a MUL/ADD pair of cycles,
// with overflow / bad-digit detection and a valid/ready result port.
module d2b_entry_ctrl
  import d2b_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned MAX_DIGITS = 5
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              digit_pulse,
  input  logic [DIGIT_W-1:0]                digit_val,
  input  logic                              enter_pulse,
  input  logic                              clear_pulse,
  input  logic                              out_ready,
  output logic [WIDTH-1:0]                  bin_out,
  output logic                              out_valid,
  output logic [$clog2(MAX_DIGITS+1)-1:0]   digit_cnt,
  output logic                              busy,
  output logic                              overflow,
  output logic                              bad_digit
);

  localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     tmp_q, tmp_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DIGIT_W-1:0]   digit_q, digit_d;
  logic                 enter_pend_q, enter_pend_d;
  logic                 bad_digit_q, bad_digit_d;

  logic                 digit_ok_c;
  logic                 enter_req_c;
  logic                 xfer_c;
  logic [WIDTH+3:0]     prod_c;
  logic                 mul_ovf_c;
  logic [WIDTH:0]       sum_c;
  logic                 add_cry_c;

  d2b_mul10 #(.WIDTH(WIDTH)) u_mul10 (
    .x_i    (acc_q),
    .prod_o (prod_c)
  );

  assign digit_ok_c  = digit_pulse && (digit_val <= MAX_DEC_DIGIT)
                       && (cnt_q < CNT_W'(MAX_DIGITS));
  assign enter_req_c = enter_pulse || enter_pend_q;
  assign xfer_c      = (state_q == ST_HOLD) && out_ready;
  assign mul_ovf_c   = |prod_c[WIDTH+3:WIDTH];
  assign sum_c       = (WIDTH+1)'(tmp_q) + (WIDTH+1)'(digit_q);
  assign add_cry_c   = sum_c[WIDTH];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear overrides everything
  always_comb begin
    state_d = state_q;
    if (clear_pulse) begin
      state_d = ST_COLLECT;
    end else begin
      unique case (state_q)
        ST_COLLECT: begin
          if (digit_ok_c)       state_d = ST_MUL;
          else if (enter_req_c) state_d = ST_HOLD;
        end
        ST_MUL:  state_d = mul_ovf_c ? ST_ERR : ST_ADD;
        ST_ADD:  state_d = add_cry_c ? ST_ERR : ST_COLLECT;
        ST_HOLD: if (xfer_c) state_d = ST_COLLECT;
        ST_ERR:  state_d = ST_ERR;
        default: state_d = ST_COLLECT;
      endcase
    end
  end

  // Datapath and flag next values
  always_comb begin
    acc_d        = acc_q;
    tmp_d        = tmp_q;
    cnt_d        = cnt_q;
    digit_d      = digit_q;
    enter_pend_d = enter_pend_q;
    bad_digit_d  = 1'b0;
    if (clear_pulse) begin
      acc_d        = '0;
      cnt_d        = '0;
      enter_pend_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_COLLECT: begin
          if (digit_ok_c) begin
            digit_d = digit_val;
            if (enter_pulse) enter_pend_d = 1'b1;
          end else begin
            bad_digit_d = digit_pulse;
            if (enter_req_c) enter_pend_d = 1'b0;
          end
        end
        ST_MUL: begin
          tmp_d       = prod_c[WIDTH-1:0];
          bad_digit_d = digit_pulse;
          if (enter_pulse) enter_pend_d = 1'b1;
        end
        ST_ADD: begin
          bad_digit_d = digit_pulse;
          if (enter_pulse) enter_pend_d = 1'b1;
          if (!add_cry_c) begin
            acc_d = sum_c[WIDTH-1:0];
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          bad_digit_d = digit_pulse;
          if (xfer_c) begin
            acc_d = '0;
            cnt_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q        <= '0;
      tmp_q        <= '0;
      cnt_q        <= '0;
      digit_q      <= '0;
      enter_pend_q <= 1'b0;
      bad_digit_q  <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      tmp_q        <= tmp_d;
      cnt_q        <= cnt_d;
      digit_q      <= digit_d;
      enter_pend_q <= enter_pend_d;
      bad_digit_q  <= bad_digit_d;
    end
  end

  // Outputs decode registered state only
  always_comb begin
    bin_out   = acc_q;
    digit_cnt = cnt_q;
    bad_digit = bad_digit_q;
    out_valid = (state_q == ST_HOLD);
    busy      = (state_q == ST_MUL) || (state_q == ST_ADD);
    overflow  = (state_q == ST_ERR);
  end

endmodule

// File: tb/tb_d2b_entry_ctrl.sv
// Directed plus randomized bench for d2b_entry_ctrl against an integer-arithmetic entry model.
module tb_d2b_entry_ctrl;

  logic        clk;
  logic        rst_n;
  logic        digit_pulse;
  logic [3:0]  digit_val;
  logic        enter_pulse;
  logic        clear_pulse;
  logic        out_ready;
  logic [15:0] bin_out;
  logic        out_valid;
  logic [2:0]  digit_cnt;
  logic        busy;
  logic        overflow;
  logic        bad_digit;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: value of the entry so far, digit count, sticky error
  int m_acc = 0;
  int m_cnt = 0;
  bit m_err = 1'b0;

  d2b_entry_ctrl #(.WIDTH(16), .MAX_DIGITS(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digit_pulse (digit_pulse),
    .digit_val   (digit_val),
    .enter_pulse (enter_pulse),
    .clear_pulse (clear_pulse),
    .out_ready   (out_ready),
    .bin_out     (bin_out),
    .out_valid   (out_valid),
    .digit_cnt   (digit_cnt),
    .busy        (busy),
    .overflow    (overflow),
    .bad_digit   (bad_digit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_acc = 0;
    m_cnt = 0;
    m_err = 1'b0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_bin"}, 32'(bin_out), 32'(m_acc));
    chk({tag, "_cnt"}, 32'(digit_cnt), 32'(m_cnt));
    chk({tag, "_ovf"}, 32'(overflow), 32'(m_err));
  endtask

  // One digit pulse in COLLECT, then let the MUL/ADD pair complete
  task automatic send_digit(input int v);
    bit ok;
    longint nv;
    ok = (v <= 9) && (m_cnt < 5);
    digit_val   = 4'(v);
    digit_pulse = 1'b1;
    tick();
    digit_pulse = 1'b0;
    chk("dig_bad", 32'(bad_digit), 32'(!ok));
    chk("dig_busy", 32'(busy), 32'(ok));
    if (ok) begin
      nv = longint'(m_acc) * 10 + longint'(v);
      if (nv > 65535) m_err = 1'b1;
      else begin
        m_acc = int'(nv);
        m_cnt++;
      end
    end
    tick();
    if (!ok) chk("dig_bad_1cyc", 32'(bad_digit), 32'd0);
    tick();
    check_state("dig");
  endtask

  task automatic send_enter();
    enter_pulse = 1'b1;
    tick();
    enter_pulse = 1'b0;
    chk("ent_valid", 32'(out_valid), 32'(!m_err));
    chk("ent_bin", 32'(bin_out), 32'(m_acc));
  endtask

  // Hold with ready low for n cycles, then transfer
  task automatic take(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_bin", 32'(bin_out), 32'(m_acc));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    model_reset();
    chk("xfer_valid", 32'(out_valid), 32'd0);
    check_state("xfer");
  endtask

  task automatic send_clear();
    clear_pulse = 1'b1;
    tick();
    clear_pulse = 1'b0;
    model_reset();
    chk("clr_valid", 32'(out_valid), 32'd0);
    check_state("clr");
  endtask

  initial begin
    int nd;
    int v;
    rst_n       = 1'b0;
    digit_pulse = 1'b0;
    digit_val   = '0;
    enter_pulse = 1'b0;
    clear_pulse = 1'b0;
    out_ready   = 1'b0;
    #12;
    chk("rst_bin", 32'(bin_out), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_cnt", 32'(digit_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_bad", 32'(bad_digit), 32'd0);
    rst_n = 1'b1;
    tick();

    // 123 with ready held low for 3 cycles
    send_digit(1); send_digit(2); send_digit(3);
    chk("t1_val123", 32'(bin_out), 32'h7B);
    send_enter();
    take(3);

    // Largest value, ADD carry, MUL overflow
    send_digit(6); send_digit(5); send_digit(5); send_digit(3); send_digit(5);
    chk("t2_max", 32'(bin_out), 32'd65535);
    send_enter();
    take(1);
    send_digit(6); send_digit(5); send_digit(5); send_digit(3); send_digit(6);
    chk("t2_addcry", 32'(overflow), 32'd1);
    send_enter();
    send_clear();
    send_digit(9); send_digit(9); send_digit(9); send_digit(9); send_digit(9);
    chk("t2_mulovf", 32'(overflow), 32'd1);
    send_clear();

    // Illegal digit value, sixth digit
    send_digit(10);
    send_digit(1); send_digit(2); send_digit(3); send_digit(4); send_digit(5);
    send_digit(6);
    chk("t3_cnt_sat", 32'(digit_cnt), 32'd5);
    send_enter();
    take(0);

    // Digit during MUL dropped, enter during ADD remembered
    digit_val = 4'd4; digit_pulse = 1'b1;
    tick();
    chk("t4_nobad", 32'(bad_digit), 32'd0);
    digit_val = 4'd7;
    tick();
    digit_pulse = 1'b0;
    chk("t4_bad_mul", 32'(bad_digit), 32'd1);
    enter_pulse = 1'b1;
    tick();
    enter_pulse = 1'b0;
    tick();
    m_acc = 4; m_cnt = 1;
    chk("t4_valid", 32'(out_valid), 32'd1);
    chk("t4_bin", 32'(bin_out), 32'd4);
    take(1);

    // Clear beats enter; digit+enter together
    send_digit(4); send_digit(2);
    chk("t5_acc42", 32'(bin_out), 32'd42);
    clear_pulse = 1'b1; enter_pulse = 1'b1;
    tick();
    clear_pulse = 1'b0; enter_pulse = 1'b0;
    model_reset();
    check_state("t5_clr");
    tick();
    chk("t5_novalid", 32'(out_valid), 32'd0);
    send_digit(5);
    digit_val = 4'd3; digit_pulse = 1'b1; enter_pulse = 1'b1;
    tick();
    digit_pulse = 1'b0; enter_pulse = 1'b0;
    tick(); tick(); tick();
    m_acc = 53; m_cnt = 2;
    chk("t5_valid", 32'(out_valid), 32'd1);
    chk("t5_bin", 32'(bin_out), 32'd53);
    take(1);

    // Asynchronous reset in the middle of ADD
    send_digit(1);
    digit_val = 4'd2; digit_pulse = 1'b1;
    tick();
    digit_pulse = 1'b0;
    tick();
    chk("t6_busy_add", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_valid", 32'(out_valid), 32'd0);
    chk("t6_rst_bad", 32'(bad_digit), 32'd0);
    check_state("t6_rst");
    #1 rst_n = 1'b1;
    tick();
    send_digit(8);
    send_enter();
    chk("t6_bin8", 32'(bin_out), 32'd8);
    take(0);

    // Random entries against the model
    for (int e = 0; e < 30; e++) begin
      nd = int'($urandom_range(0, 6));
      for (int d = 0; d < nd && !m_err; d++) begin
        if ($urandom_range(0, 9) == 0) v = int'($urandom_range(10, 15));
        else v = int'($urandom_range(0, 9));
        send_digit(v);
      end
      if (m_err) send_clear();
      else begin
        send_enter();
        take(int'($urandom_range(0, 3)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
